// File: rtl/row_packet_decoder_pkg.sv
// Shared packet constants, FSM states and the event record used by the
// row packet decoder and its testbench.
package row_packet_decoder_pkg;

  localparam logic [15:0] WRAP_MARKER = 16'h8000;
  localparam int          MSB_BIT     = 15;

  typedef enum logic {
    RUN   = 1'b0,
    EPOCH = 1'b1
  } state_e;

  // 46-bit event: pixel word, {epoch, low_time}, stamped flag
  typedef struct packed {
    logic [14:0] pixels;
    logic [29:0] tstamp;
    logic        stamped;
  } evt_t;

endpackage

// File: rtl/row_packet_decoder_evt_fifo.sv
// Width/depth parameterised synchronous FIFO; a push into a full FIFO is
// accepted when a pop happens in the same cycle.
module evt_fifo #(
  parameter int W     = 46,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic [W-1:0] rd_data_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW:0]   wr_ptr_q, rd_ptr_q;
  logic          do_push, do_pop;

  // Extra pointer bit separates full from empty at equal addresses
  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full_o    = ((wr_ptr_q ^ rd_ptr_q) == {1'b1, {AW{1'b0}}});
  assign do_pop    = pop_i && !empty_o;
  assign do_push   = push_i && (!full_o || do_pop);
  assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

endmodule

// File: rtl/row_packet_decoder.sv
// Decodes the row encoder packet stream into time-tagged pixel events and
// buffers them behind a valid/ready interface.
module row_packet_decoder
  import row_packet_decoder_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PIX_W = 15,
  parameter int TS_W  = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              data_ready,
  input  logic [15:0]       encoded_data,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [PIX_W-1:0]  evt_pixels,
  output logic [2*TS_W-1:0] evt_time,
  output logic              evt_stamped,
  output logic              overflow,
  output logic              proto_err
);

  localparam int EW = PIX_W + 2*TS_W + 1;

  state_e           st_q, st_d;
  logic [TS_W-1:0]  epoch_q, epoch_d, low_q, low_d;
  logic             pend_q, pend_d;
  logic             ovf_q, perr_q, perr_d;
  logic             push, pop, full, empty, is_msb, is_marker;
  logic [EW-1:0]    push_data, head;

  assign is_msb    = encoded_data[MSB_BIT];
  assign is_marker = (encoded_data == WRAP_MARKER);
  assign push_data = {encoded_data[PIX_W-1:0], epoch_q, low_q, pend_q};

  always_comb begin
    st_d    = st_q;
    epoch_d = epoch_q;
    low_d   = low_q;
    pend_d  = pend_q;
    perr_d  = perr_q;
    push    = 1'b0;
    if (data_ready) begin
      if (st_q == EPOCH && !is_msb) begin
        epoch_d = encoded_data[TS_W-1:0];
        low_d   = '0;
        st_d    = RUN;
      end else begin
        // An MSB=1 word while awaiting the epoch is flagged, then handled normally
        if (st_q == EPOCH) perr_d = 1'b1;
        if (is_marker) begin
          st_d = EPOCH;
        end else if (is_msb) begin
          low_d  = encoded_data[TS_W-1:0];
          pend_d = 1'b1;
        end else begin
          push   = 1'b1;
          pend_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q    <= RUN;
      epoch_q <= '0;
      low_q   <= '0;
      pend_q  <= 1'b0;
      perr_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      st_q    <= st_d;
      epoch_q <= epoch_d;
      low_q   <= low_d;
      pend_q  <= pend_d;
      perr_q  <= perr_d;
      if (push && full && !pop) ovf_q <= 1'b1;
    end
  end

  assign pop = evt_valid && evt_ready;

  evt_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (pop),
    .rd_data_o   (head),
    .full_o      (full),
    .empty_o     (empty)
  );

  assign evt_valid                           = !empty;
  assign {evt_pixels, evt_time, evt_stamped} = head;
  assign overflow                            = ovf_q;
  assign proto_err                           = perr_q;

endmodule
